// File: rtl/loader_pkg.sv
// Shared types and constants for the bit-serial program loader.
package loader_pkg;

    localparam int INS_W  = 6;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    localparam logic [INS_W-1:0] CHK_INIT = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/serial_word_rx.sv
// MSB-first serial-to-parallel word receiver with a clearable bit counter.
module serial_word_rx
    import loader_pkg::*;
(
    input  logic             clk,
    input  logic             nReset,
    input  logic             clr,
    input  logic             sdi,
    input  logic             sdi_valid,
    output logic [INS_W-1:0] word,
    output logic             word_done
);

    localparam logic [2:0] LAST_BIT = 3'(INS_W - 1);

    logic [2:0]       bit_cnt_reg;
    logic [INS_W-1:0] shift_reg;

    // The completed word is presented in the same cycle its last bit is valid,
    // so the consumer can register it on the very edge that samples that bit.
    assign word      = {shift_reg[INS_W-2:0], sdi};
    assign word_done = sdi_valid & ~clr & (bit_cnt_reg == LAST_BIT);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else if (clr) begin
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else if (sdi_valid) begin
            shift_reg   <= word;
            bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? 3'd0 : bit_cnt_reg + 3'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Framed program loader: length word, instruction words, XOR checksum.
// Writes program memory and holds the CPU in reset while a frame is loading.
module program_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    input  logic              sdi,
    input  logic              sdi_valid,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_waddr,
    output logic [INS_W-1:0]  pm_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [INS_W-1:0] DEPTH_W = INS_W'(DEPTH);

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] last_idx_reg;
    logic [INS_W-1:0]  xor_reg;
    logic              pm_we_reg;
    logic [ADDR_W-1:0] pm_waddr_reg;
    logic [INS_W-1:0]  pm_wdata_reg;
    logic              cpu_hold_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    logic              rx_clr;
    logic              rx_valid;
    logic [INS_W-1:0]  rx_word;
    logic              rx_done;

    // Serial input only advances while a frame is in progress; a start
    // outside a frame resets the deserialiser for the new length word.
    assign rx_clr   = start & ~busy_reg;
    assign rx_valid = sdi_valid & busy_reg;

    serial_word_rx u_rx (
        .clk       (clk),
        .nReset    (nReset),
        .clr       (rx_clr),
        .sdi       (sdi),
        .sdi_valid (rx_valid),
        .word      (rx_word),
        .word_done (rx_done)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            last_idx_reg <= '0;
            xor_reg      <= CHK_INIT;
            pm_we_reg    <= 1'b0;
            pm_waddr_reg <= '0;
            pm_wdata_reg <= '0;
            cpu_hold_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            pm_we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_reg    <= ST_LEN;
                        busy_reg     <= 1'b1;
                        idx_reg      <= '0;
                        xor_reg      <= CHK_INIT;
                        done_reg     <= 1'b0;
                        err_reg      <= 1'b0;
                        cpu_hold_reg <= 1'b1;
                    end
                end
                ST_LEN: begin
                    if (rx_done) begin
                        if (rx_word >= DEPTH_W) begin
                            state_reg <= ST_ERR;
                            busy_reg  <= 1'b0;
                            err_reg   <= 1'b1;
                        end else begin
                            last_idx_reg <= rx_word[ADDR_W-1:0];
                            state_reg    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_done) begin
                        pm_we_reg    <= 1'b1;
                        pm_waddr_reg <= idx_reg;
                        pm_wdata_reg <= rx_word;
                        xor_reg      <= xor_reg ^ rx_word;
                        // Stop incrementing on the last word so a full-depth frame never wraps.
                        if (idx_reg == last_idx_reg) begin
                            state_reg <= ST_CHK;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_CHK: begin
                    if (rx_done) begin
                        busy_reg <= 1'b0;
                        if (rx_word == xor_reg) begin
                            state_reg    <= ST_DONE;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_ERR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign pm_we    = pm_we_reg;
    assign pm_waddr = pm_waddr_reg;
    assign pm_wdata = pm_wdata_reg;
    assign cpu_hold = cpu_hold_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, checksum/length errors, gaps, reset.
module tb_program_loader;

    logic       clk;
    logic       nReset;
    logic       start;
    logic       sdi;
    logic       sdi_valid;
    logic       pm_we;
    logic [4:0] pm_waddr;
    logic [5:0] pm_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [10:0] wq[$];

    program_loader dut (
        .clk       (clk),
        .nReset    (nReset),
        .start     (start),
        .sdi       (sdi),
        .sdi_valid (sdi_valid),
        .pm_we     (pm_we),
        .pm_waddr  (pm_waddr),
        .pm_wdata  (pm_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe cycle, sampled away from the active edge.
    always @(negedge clk) begin
        if (pm_we === 1'b1) wq.push_back({pm_waddr, pm_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        sdi_valid = 1'b1;
        sdi = 1'b1;
        tick();
        start = 1'b0;
        sdi_valid = 1'b0;
    endtask

    // Sends one word MSB first; optional random gaps with optional start pulses in them.
    task automatic send_word(input logic [5:0] w, input int gap_max, input bit gap_start);
        for (int i = 5; i >= 0; i--) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int k = 0; k < g; k++) begin
                start = gap_start & (k == 0);
                sdi = ~w[i];
                tick();
                start = 1'b0;
            end
            sdi = w[i];
            sdi_valid = 1'b1;
            tick();
            sdi_valid = 1'b0;
        end
    endtask

    task automatic apply_reset();
        nReset = 1'b0;
        repeat (2) tick();
        nReset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        start = 1'b0;
        sdi = 1'b0;
        sdi_valid = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({pm_we, pm_waddr, pm_wdata} !== 12'd0) $display("FAIL reset_wr: got %b/%0d/%0h want 0/0/0", pm_we, pm_waddr, pm_wdata); else pass_cnt++;
        total_cnt++;
        if ({cpu_hold, busy, done, err} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {cpu_hold, busy, done, err}); else pass_cnt++;
        nReset = 1'b1;
        tick();
        $display("reset: hold/busy/done/err=%b", {cpu_hold, busy, done, err});
    endtask

    // Frame of three words; checks write latency on each data word.
    task automatic test_normal();
        logic [5:0] d[3] = '{6'h11, 6'h22, 6'h05};
        wq.delete();
        do_start();
        total_cnt++;
        if ({busy, cpu_hold} !== 2'b11) $display("FAIL start_flags: got busy/hold=%b want 11", {busy, cpu_hold}); else pass_cnt++;
        send_word(6'd2, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_word(d[i], 0, 1'b0);
            total_cnt++;
            if ({pm_we, pm_waddr, pm_wdata} !== {1'b1, 5'(i), d[i]})
                $display("FAIL normal_wr%0d: got we=%b a=%0d d=%0h want we=1 a=%0d d=%0h", i, pm_we, pm_waddr, pm_wdata, i, d[i]);
            else pass_cnt++;
            $display("write: addr=%0d data=%0h", pm_waddr, pm_wdata);
        end
        send_word(6'h36, 0, 1'b0);
        total_cnt++;
        if ({done, err, cpu_hold, busy} !== 4'b1000) $display("FAIL normal_end: got done/err/hold/busy=%b want 1000", {done, err, cpu_hold, busy}); else pass_cnt++;
        tick();
        total_cnt++;
        if (wq.size() !== 3) $display("FAIL normal_count: got %0d writes want 3", wq.size()); else pass_cnt++;
        total_cnt++;
        if (pm_we !== 1'b0 || pm_waddr !== 5'd2 || pm_wdata !== 6'h05) $display("FAIL normal_hold: got we=%b a=%0d d=%0h want 0/2/5", pm_we, pm_waddr, pm_wdata); else pass_cnt++;
    endtask

    task automatic test_bad_chk();
        wq.delete();
        do_start();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL bad_start_done: got %b want 0", done); else pass_cnt++;
        send_word(6'd2, 0, 1'b0);
        send_word(6'h11, 0, 1'b0);
        send_word(6'h22, 0, 1'b0);
        send_word(6'h05, 0, 1'b0);
        send_word(6'h35, 0, 1'b0);
        tick();
        total_cnt++;
        if ({done, err, cpu_hold, busy} !== 4'b0110) $display("FAIL bad_chk: got done/err/hold/busy=%b want 0110", {done, err, cpu_hold, busy}); else pass_cnt++;
        total_cnt++;
        if (wq.size() !== 3) $display("FAIL bad_count: got %0d writes want 3", wq.size()); else pass_cnt++;
        $display("bad checksum: err=%b writes=%0d", err, wq.size());
    endtask

    task automatic test_oversize();
        wq.delete();
        do_start();
        send_word(6'd40, 0, 1'b0);
        total_cnt++;
        if ({err, busy, cpu_hold} !== 3'b101) $display("FAIL oversize: got err/busy/hold=%b want 101", {err, busy, cpu_hold}); else pass_cnt++;
        // Further serial data must be ignored in ERR.
        send_word(6'h2a, 0, 1'b0);
        send_word(6'h15, 0, 1'b0);
        total_cnt++;
        if (wq.size() !== 0 || state_busy_any()) $display("FAIL oversize_writes: got %0d writes busy=%b want 0/0", wq.size(), busy); else pass_cnt++;
        $display("oversize: err=%b writes=%0d", err, wq.size());
    endtask

    function automatic bit state_busy_any();
        return busy !== 1'b0;
    endfunction

    task automatic test_full();
        logic [5:0] x;
        int bad;
        x = 6'd0;
        bad = 0;
        wq.delete();
        do_start();
        send_word(6'd31, 0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            send_word(6'(i), 0, 1'b0);
            x = x ^ 6'(i);
        end
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL full_busy: got %b want 1", busy); else pass_cnt++;
        send_word(x, 0, 1'b0);
        tick();
        total_cnt++;
        if ({done, err, cpu_hold} !== 3'b100) $display("FAIL full_end: got done/err/hold=%b want 100", {done, err, cpu_hold}); else pass_cnt++;
        for (int i = 0; i < wq.size() && i < 32; i++)
            if (wq[i] !== {5'(i), 6'(i)}) bad++;
        total_cnt++;
        if (wq.size() !== 32 || bad != 0) $display("FAIL full_writes: got %0d writes %0d wrong want 32/0", wq.size(), bad); else pass_cnt++;
        $display("full depth: writes=%0d done=%b", wq.size(), done);
    endtask

    task automatic test_gappy();
        logic [5:0] d[3] = '{6'h11, 6'h22, 6'h05};
        int bad;
        bad = 0;
        wq.delete();
        do_start();
        send_word(6'd2, 5, 1'b1);
        for (int i = 0; i < 3; i++) send_word(d[i], 5, 1'b1);
        send_word(6'h36, 5, 1'b1);
        tick();
        total_cnt++;
        if ({done, err, cpu_hold, busy} !== 4'b1000) $display("FAIL gappy_end: got done/err/hold/busy=%b want 1000", {done, err, cpu_hold, busy}); else pass_cnt++;
        for (int i = 0; i < wq.size() && i < 3; i++)
            if (wq[i] !== {5'(i), d[i]}) bad++;
        total_cnt++;
        if (wq.size() !== 3 || bad != 0) $display("FAIL gappy_writes: got %0d writes %0d wrong want 3/0", wq.size(), bad); else pass_cnt++;
        $display("gappy: writes=%0d done=%b", wq.size(), done);
    endtask

    task automatic test_reset_mid();
        wq.delete();
        do_start();
        send_word(6'd2, 0, 1'b0);
        send_word(6'h11, 0, 1'b0);
        sdi = 1'b1;
        sdi_valid = 1'b1;
        repeat (3) tick();
        sdi_valid = 1'b0;
        #2;
        nReset = 1'b0;
        #1;
        total_cnt++;
        if ({pm_we, pm_waddr, pm_wdata, cpu_hold, busy, done, err} !== 16'd0)
            $display("FAIL reset_mid: got we=%b a=%0d d=%0h hold/busy/done/err=%b want all 0", pm_we, pm_waddr, pm_wdata, {cpu_hold, busy, done, err});
        else pass_cnt++;
        @(negedge clk);
        nReset = 1'b1;
        tick();
        wq.delete();
        do_start();
        send_word(6'd1, 0, 1'b0);
        send_word(6'h0c, 0, 1'b0);
        send_word(6'h30, 0, 1'b0);
        send_word(6'h3c, 0, 1'b0);
        tick();
        total_cnt++;
        if ({done, err, cpu_hold} !== 3'b100) $display("FAIL reload_end: got done/err/hold=%b want 100", {done, err, cpu_hold}); else pass_cnt++;
        total_cnt++;
        if (wq.size() !== 2 || wq[0] !== {5'd0, 6'h0c} || wq[1] !== {5'd1, 6'h30})
            $display("FAIL reload_writes: got %0d writes want 2 (0c@0, 30@1)", wq.size());
        else pass_cnt++;
        $display("reset mid-frame then reload: writes=%0d done=%b", wq.size(), done);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_chk();
        test_oversize();
        test_full();
        test_gappy();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
